// File: rtl/arp_tx.sv
// arp_tx: ARP frame transmitter for the GMII TX path.
// A one-cycle request produces one Ethernet II frame. The frame carries the
// preamble/SFD, the Ethernet header, the 28-byte ARP payload, and zero
// padding to 60 bytes. A 12-cycle inter-frame gap follows the frame.
// Optional feature macro: ARP_TX_FCS_EN. When it is defined, the block
// computes a CRC-32 and appends the 4-byte FCS (72 GMII bytes). When it is
// undefined, the frame is 68 GMII bytes and a downstream block adds the FCS.
// Every output is registered. The output stage runs one cycle behind the
// state register, so the first 0x55 appears one edge after the request is
// accepted.
module arp_tx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd
);

  typedef enum logic [6:0] {
    st_idle     = 7'b0000001,
    st_preamble = 7'b0000010,
    st_eth_head = 7'b0000100,
    st_arp_data = 7'b0001000,
    st_pad      = 7'b0010000,
    st_crc      = 7'b0100000,
    st_ifg      = 7'b1000000
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_next;
  logic        w_accept;
  logic        w_last_ifg;
  logic        w_active;
  logic [7:0]  w_byte;
  logic [47:0] w_dst_mac;
  logic [47:0] w_tgt_mac;

  logic        r_type;
  logic [47:0] r_mac;
  logic [31:0] r_ip;

  logic        r_tx_en;
  logic [7:0]  r_txd;
  logic        r_done;
  logic        r_busy;

  // Byte idx (0 = most significant) of a 48-bit address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [4:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      5'd0: b = mac[47:40];
      5'd1: b = mac[39:32];
      5'd2: b = mac[31:24];
      5'd3: b = mac[23:16];
      5'd4: b = mac[15:8];
      5'd5: b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Byte idx (0 = most significant) of a 32-bit IPv4 address.
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [4:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      5'd0: b = ip[31:24];
      5'd1: b = ip[23:16];
      5'd2: b = ip[15:8];
      5'd3: b = ip[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef ARP_TX_FCS_EN
  logic [31:0] r_crc;
  logic [31:0] w_fcs;

  // Reflected CRC-32, one byte per call, data LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = {1'b0, c[31:1]} ^ 32'hEDB8_8320;
      else                c = {1'b0, c[31:1]};
    end
    return c;
  endfunction

  assign w_fcs = ~r_crc;
`endif

  // A request is honoured in idle. It is also honoured on the final IFG
  // cycle, which allows back-to-back frames at the minimum spacing.
  assign w_last_ifg = (r_state == st_ifg) && (r_cnt == 5'd11);
  assign w_accept   = arp_tx_en && ((r_state == st_idle) || w_last_ifg);

  assign w_dst_mac = r_type ? r_mac : 48'hFFFF_FFFF_FFFF;
  assign w_tgt_mac = r_type ? r_mac : 48'h0000_0000_0000;

  assign w_active = (r_state == st_preamble) || (r_state == st_eth_head) ||
                    (r_state == st_arp_data) || (r_state == st_pad) ||
                    (r_state == st_crc);

  // State register and byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= st_idle;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. The counter restarts on every state change.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      st_idle:     if (w_accept) w_state_next = st_preamble;
      st_preamble: if (r_cnt == 5'd7) w_state_next = st_eth_head;
      st_eth_head: if (r_cnt == 5'd13) w_state_next = st_arp_data;
      st_arp_data: if (r_cnt == 5'd27) w_state_next = st_pad;
`ifdef ARP_TX_FCS_EN
      st_pad:      if (r_cnt == 5'd17) w_state_next = st_crc;
`else
      st_pad:      if (r_cnt == 5'd17) w_state_next = st_ifg;
`endif
      st_crc:      if (r_cnt == 5'd3) w_state_next = st_ifg;
      st_ifg:      if (w_last_ifg) w_state_next = w_accept ? st_preamble : st_idle;
      default:     w_state_next = st_idle;
    endcase
    w_cnt_next = ((w_state_next != r_state) || (r_state == st_idle)) ? 5'd0 : r_cnt + 5'd1;
  end

  // Capture the request fields on accept so that later input changes do not disturb the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type <= 1'b0;
      r_mac  <= 48'h0;
      r_ip   <= 32'h0;
    end else if (w_accept) begin
      r_type <= arp_tx_type;
      r_mac  <= des_mac;
      r_ip   <= des_ip;
    end
  end

  // Select the frame byte for the current state and count.
  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      st_preamble: w_byte = (r_cnt == 5'd7) ? 8'hD5 : 8'h55;
      st_eth_head: begin
        if (r_cnt < 5'd6)        w_byte = mac_byte(w_dst_mac, r_cnt);
        else if (r_cnt < 5'd12)  w_byte = mac_byte(BOARD_MAC, r_cnt - 5'd6);
        else if (r_cnt == 5'd12) w_byte = 8'h08;
        else                     w_byte = 8'h06;
      end
      st_arp_data: begin
        case (r_cnt)
          5'd0, 5'd3, 5'd6: w_byte = 8'h00;
          5'd1:             w_byte = 8'h01;
          5'd2:             w_byte = 8'h08;
          5'd4:             w_byte = 8'h06;
          5'd5:             w_byte = 8'h04;
          5'd7:             w_byte = r_type ? 8'h02 : 8'h01;
          default: begin
            if (r_cnt < 5'd14)      w_byte = mac_byte(BOARD_MAC, r_cnt - 5'd8);
            else if (r_cnt < 5'd18) w_byte = ip_byte(BOARD_IP, r_cnt - 5'd14);
            else if (r_cnt < 5'd24) w_byte = mac_byte(w_tgt_mac, r_cnt - 5'd18);
            else                    w_byte = ip_byte(r_ip, r_cnt - 5'd24);
          end
        endcase
      end
`ifdef ARP_TX_FCS_EN
      st_crc: begin
        case (r_cnt[1:0])
          2'd0:    w_byte = w_fcs[7:0];
          2'd1:    w_byte = w_fcs[15:8];
          2'd2:    w_byte = w_fcs[23:16];
          default: w_byte = w_fcs[31:24];
        endcase
      end
`endif
      default: w_byte = 8'h00;
    endcase
  end

`ifdef ARP_TX_FCS_EN
  // CRC: preset just before the first header byte, then fold in header, payload and pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 32'h0;
    end else if ((r_state == st_preamble) && (r_cnt == 5'd7)) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if ((r_state == st_eth_head) || (r_state == st_arp_data) || (r_state == st_pad)) begin
      r_crc <= crc32_byte(r_crc, w_byte);
    end
  end
`endif

  // Output registers. Data is forced to zero outside the frame, and busy drops on the final IFG cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_en <= 1'b0;
      r_txd   <= 8'h00;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tx_en <= w_active;
      r_txd   <= w_active ? w_byte : 8'h00;
      r_done  <= (r_state == st_ifg) && (r_cnt == 5'd0);
      r_busy  <= (r_state != st_idle) && !w_last_ifg;
    end
  end

  assign gmii_tx_en = r_tx_en;
  assign gmii_txd   = r_txd;
  assign tx_done    = r_done;
  assign tx_busy    = r_busy;

endmodule

// File: tb/tb_arp_tx.sv
// Testbench for arp_tx. A reference model assembles each frame from the
// field rules, and a monitor checks the GMII output against that
// scoreboard.
module tb_arp_tx;

`ifdef ARP_TX_FCS_EN
  localparam int FRAME = 72;
  localparam bit FCS   = 1'b1;
`else
  localparam int FRAME = 68;
  localparam bit FCS   = 1'b0;
`endif
  localparam int PERIOD = FRAME + 12;
  localparam logic [47:0] B_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] B_IP  = 32'hC0A8_010A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arp_tx_en = 1'b0;
  logic        arp_tx_type = 1'b0;
  logic [47:0] des_mac = 48'h0;
  logic [31:0] des_ip = 32'h0;
  logic        tx_busy, tx_done, gmii_tx_en;
  logic [7:0]  gmii_txd;

  arp_tx dut (
    .clk(clk), .rst_n(rst_n), .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
    .des_mac(des_mac), .des_ip(des_ip), .tx_busy(tx_busy), .tx_done(tx_done),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd)
  );

  always #4 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [7:0] exp_bytes[$];
  int         exp_start[$];
  int         exp_done[$];
  int total = 0, bad = 0;
  int next_ok = 0, last_acc = 0, frames = 0;
  logic in_frame = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h at edge %0d", name, act, req, edge_cnt);
    end
  endtask

  // Reference frame built from the field rules: header, payload, pad to 60, then the optional FCS.
  task automatic push_frame(input logic t, input logic [47:0] m, input logic [31:0] ip);
    logic [7:0]  fr[$];
    logic [47:0] dst, tgt;
    logic [31:0] c;
    dst = t ? m : 48'hFFFF_FFFF_FFFF;
    tgt = t ? m : 48'h0;
    for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(B_MAC[47-8*i -: 8]);
    fr.push_back(8'h08); fr.push_back(8'h06);
    fr.push_back(8'h00); fr.push_back(8'h01); fr.push_back(8'h08); fr.push_back(8'h00);
    fr.push_back(8'h06); fr.push_back(8'h04); fr.push_back(8'h00);
    fr.push_back(t ? 8'h02 : 8'h01);
    for (int i = 0; i < 6; i++) fr.push_back(B_MAC[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) fr.push_back(B_IP[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(tgt[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) fr.push_back(ip[31-8*i -: 8]);
    while (fr.size() < 60) fr.push_back(8'h00);
    if (FCS) begin
      c = 32'hFFFF_FFFF;
      foreach (fr[k]) begin
        c = c ^ {24'h0, fr[k]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    end
    for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    foreach (fr[k]) exp_bytes.push_back(fr[k]);
  endtask

  // Pulse a request at the next edge. The model accepts it only when the previous frame period has elapsed.
  task automatic send(input logic t, input logic [47:0] m, input logic [31:0] ip);
    int   n;
    logic acc;
    n = edge_cnt + 1;
    acc = (n >= next_ok);
    arp_tx_type = t; des_mac = m; des_ip = ip; arp_tx_en = 1'b1;
    if (acc) begin
      push_frame(t, m, ip);
      exp_start.push_back(n + 1);
      exp_done.push_back(n + FRAME + 1);
      next_ok = n + PERIOD;
      last_acc = n;
    end
    $display("req edge=%0d type=%0d mac=%h ip=%h accepted=%0d", n, t, m, ip, acc);
    @(negedge clk);
    arp_tx_en = 1'b0;
    arp_tx_type = 1'($urandom);
    des_mac = {16'($urandom), 32'($urandom)};
    des_ip = 32'($urandom);
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Monitor: check every output cycle against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (gmii_tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          if (exp_start.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_start act=%0d req=none", edge_cnt);
          end else chk("start_edge", edge_cnt, exp_start.pop_front());
        end
        chk("busy_in_frame", tx_busy, 1'b1);
        if (exp_bytes.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte act=%h req=none", gmii_txd);
        end else chk("frame_byte", gmii_txd, exp_bytes.pop_front());
      end else begin
        in_frame = 1'b0;
        chk("txd_idle_zero", gmii_txd, 8'h00);
      end
      if (tx_done) begin
        chk("done_txen_low", gmii_tx_en, 1'b0);
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done act=%0d req=none", edge_cnt);
        end else chk("done_edge", edge_cnt, exp_done.pop_front());
        frames++;
        $display("frame %0d done at edge %0d", frames, edge_cnt);
      end
    end
  end

  initial begin
    int a, b, off, gap;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", gmii_tx_en, 1'b0);
    chk("rst_txd", gmii_txd, 8'h00);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", tx_busy, 1'b0);

    // Request, ignored pulses mid-frame and mid-IFG, then a reply on the boundary edge.
    send(1'b0, {16'($urandom), 32'($urandom)}, 32'hC0A8_0102);
    a = last_acc;
    wait_edge(a + 29);
    send(1'b1, 48'h1234_5678_9ABC, 32'h0A0B_0C0D);
    wait_edge(a + PERIOD - 5);
    send(1'b1, 48'h1234_5678_9ABC, 32'h0A0B_0C0D);
    wait_edge(a + PERIOD - 1);
    send(1'b1, 48'hAA_BB_CC_DD_EE_FF, 32'hC0A8_0166);
    chk("b2b_accept", last_acc, a + PERIOD);

    // Reset while byte 30 of the next frame is on the wire.
    wait_edge(last_acc + PERIOD - 1);
    send(1'b1, {16'($urandom), 32'($urandom)}, 32'($urandom));
    b = last_acc;
    wait_edge(b + 31);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_txen", gmii_tx_en, 1'b0);
    chk("rst_async_txd", gmii_txd, 8'h00);
    exp_bytes.delete(); exp_start.delete(); exp_done.delete();
    next_ok = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("post_rst_busy", tx_busy, 1'b0);
    send(1'b0, {16'($urandom), 32'($urandom)}, 32'($urandom));

    // Random traffic: an ignored pulse inside each frame, then a request at or after the boundary.
    for (int f = 0; f < 16; f++) begin
      off = $urandom_range(2, PERIOD - 1);
      wait_edge(last_acc + off - 1);
      send(1'($urandom), {16'($urandom), 32'($urandom)}, 32'($urandom));
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
      wait_edge(last_acc + PERIOD + gap - 1);
      send(1'($urandom), {16'($urandom), 32'($urandom)}, 32'($urandom));
    end

    wait_edge(last_acc + PERIOD + 20);
    chk("left_bytes", exp_bytes.size(), 0);
    chk("left_done", exp_done.size(), 0);
    chk("left_start", exp_start.size(), 0);
    chk("end_busy", tx_busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
